// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - accumulates COUNT unsigned products into one registered sum with sticky overflow
module mult_accumulator #(
    parameter int PW    = 7,
    parameter int ACC_W = 9,
    parameter int COUNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_ovf;

    logic [ACC_W:0]    w_sum;
    logic              w_accept;

    // Top bit of w_sum is the carry out of the accumulator width.
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - PW){1'b0}}, product};
    assign w_accept = in_valid && (r_state == ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= ACCUM;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign acc_out   = r_acc;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - directed self-checking bench for mult_accumulator
module tb_mult_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] product;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] acc_out;
    logic       overflow;

    int checks;
    int errors;

    logic [6:0] vec [8];

    mult_accumulator #(.PW(7), .ACC_W(9), .COUNT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds vec[0..7]; gap inserts an idle cycle after each product.
    task automatic feed(input bit gap);
        for (int i = 0; i < 8; i++) begin
            check("feed_ready", in_ready, 1);
            in_valid = 1'b1;
            product  = vec[i];
            step();
            in_valid = 1'b0;
            if (i < 7) begin
                check("feed_no_valid", out_valid, 0);
                if (gap) step();
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        product   = '0;
        out_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            product   = 7'($urandom);
            clear     = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc", acc_out, 0);
        check("rst_ovf", overflow, 0);
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_acc", acc_out, 0);

        // Basic sum 1..8
        vec = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8};
        feed(1'b0);
        check("basic_valid", out_valid, 1);
        check("basic_acc", acc_out, 36);
        check("basic_ovf", overflow, 0);
        check("basic_in_ready", in_ready, 0);
        step();
        check("basic_valid_drop", out_valid, 0);
        check("basic_in_ready_back", in_ready, 1);
        check("basic_acc_zero", acc_out, 0);

        // Overflow then flag cleared
        vec = '{7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127};
        feed(1'b0);
        check("ovf_valid", out_valid, 1);
        check("ovf_acc", acc_out, 504);
        check("ovf_flag", overflow, 1);
        step();
        vec = '{7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1};
        feed(1'b0);
        check("ovf2_valid", out_valid, 1);
        check("ovf2_acc", acc_out, 8);
        check("ovf2_flag", overflow, 0);
        step();

        // Gaps and backpressure; product driven during HOLD must be ignored
        out_ready = 1'b0;
        vec = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60, 7'd70, 7'd80};
        feed(1'b1);
        in_valid = 1'b1;
        product  = 7'd99;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_acc", acc_out, 360);
            check("bp_ovf", overflow, 0);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_handoff", out_valid, 0);
        check("bp_acc_zero", acc_out, 0);
        vec = '{7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1};
        feed(1'b0);
        check("bp_next_acc", acc_out, 8);
        step();

        // Clear mid-accumulation with a product in the same cycle
        in_valid = 1'b1;
        product  = 7'd5;
        for (int i = 0; i < 3; i++) step();
        check("clr_partial", acc_out, 15);
        clear   = 1'b1;
        product = 7'd7;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_acc", acc_out, 0);
        check("clr_in_ready", in_ready, 1);
        out_ready = 1'b0;
        vec = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8};
        feed(1'b0);
        check("clr_result", acc_out, 36);
        check("clr_result_valid", out_valid, 1);

        // Clear during HOLD: held result never handed off
        clear = 1'b1;
        step();
        clear     = 1'b0;
        check("clr_hold_valid", out_valid, 0);
        check("clr_hold_acc", acc_out, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("clr_hold_no_valid", out_valid, 0);
        end

        // Async reset between edges while holding 36
        out_ready = 1'b0;
        feed(1'b0);
        check("ar_valid", out_valid, 1);
        check("ar_acc", acc_out, 36);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_drop", out_valid, 0);
        check("ar_acc_zero", acc_out, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_ovf", overflow, 0);
        step();
        rst_n = 1'b1;
        step();
        check("ar_after_valid", out_valid, 0);
        check("ar_after_acc", acc_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Downstream consumer of the combinational array multiplier. Accepts a stream of unsigned products over a valid/ready handshake, sums a fixed number of them (COUNT) into a wide accumulator, and presents each finished sum on a second valid/ready handshake with a sticky overflow flag. Upstream owns operand sequencing; this block converts the multiplier's per-cycle product into a registered dot-product-style result.

## Interface
- PW, 7, product width; matches the 4x3 multiplier output P[6:0]
- ACC_W, 9, accumulator and result width
- COUNT, 8, products summed per result; must be ≥2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort; discards the partial or held sum
- in_valid  input  1  product is present
- in_ready  output  1  block accepts a product this cycle
- product  input  PW  unsigned product from the multiplier
- out_valid  output  1  acc_out and overflow hold a finished result
- out_ready  input  1  downstream takes the result
- acc_out  output  ACC_W  finished sum, modulo 2^ACC_W
- overflow  output  1  set if any addition in this result carried out of ACC_W

One clock, clk. Reset rst_n is asynchronous and active-low.

## Operation
- States: ACCUM, HOLD. Reset state is ACCUM.
- Registers: acc[ACC_W-1:0], cnt[$clog2(COUNT)-1:0], ovf, state. All outputs are registered or decoded directly from state.
- in_ready = (state==ACCUM). out_valid = (state==HOLD).
- ACCUM: accept occurs when in_valid && in_ready. On accept:
  - {carry, acc} <= acc + zero-extended product.
  - ovf <= ovf | carry.
  - cnt <= cnt+1.
  - If cnt==COUNT-1, go to HOLD and reset cnt to 0.
- HOLD: acc_out and overflow are stable, and in_valid is ignored. When out_ready is high, go to ACCUM and zero acc and ovf in the same edge. No input is accepted in the cycle of the hand-off.
- acc_out mirrors acc at all times. Downstream must sample it only while out_valid is high.
- Arithmetic is unsigned wrap-around. The result equals the sum mod 2^ACC_W. overflow=1 iff the true sum ≥ 2^ACC_W.
- clear has priority over every other event in either state. It sets state=ACCUM and acc=cnt=ovf=0, and drops out_valid on the next edge. A product presented in the same cycle is discarded.
- Asynchronous reset mid-operation:
  - acc=0, cnt=0, ovf=0, state=ACCUM immediately.
  - in_ready=1, out_valid=0, acc_out=0, overflow=0 while rst_n is low and after release.

## Timing
- Reset values: in_ready 1, out_valid 0, acc_out 0, overflow 0.
- Throughput in ACCUM is one product per cycle, with no bubbles required.
- out_valid rises on the edge that accepts the COUNT-th product. The first cycle it is visible is the cycle after that accept.
- Minimum cycles per result is COUNT+1, i.e. COUNT accepts plus one HOLD cycle with out_ready=1.
- in_ready falls in the same cycle that out_valid rises. It rises in the cycle after the out_ready hand-off.
- out_valid, acc_out and overflow remain constant while out_ready is low, for an unbounded time.
- Gaps in in_valid pause accumulation. cnt and acc hold their values.

## Test plan
- **Reset:** hold rst_n low with random inputs, then release.
  - Required: in_ready=1, out_valid=0, acc_out=0, overflow=0.
  - Required: the first 8 accepted products after release form the first result.
- **Basic sum:** products 1..8 back-to-back, out_ready=1.
  - Required: out_valid high for exactly 1 cycle, starting 1 cycle after the 8th accept.
  - Required: acc_out=36, overflow=0.
  - Required: in_ready=0 during that cycle, then 1.
- **Overflow:** 8 products of 127.
  - Required: acc_out=1016 mod 512=504, overflow=1.
  - Follow with 8 products of 1. Required: acc_out=8, overflow=0 (flag cleared).
- **Backpressure and gaps:** products 10,20,30,40,50,60,70,80 with in_valid toggled every other cycle, then out_ready low for 5 cycles.
  - Required: acc_out=360 and out_valid held for all 5 cycles.
  - Required: in_ready=0 and a product driven during HOLD is not absorbed.
  - Required: the next result excludes that product.
- **Clear:** accept 5,5,5, pulse clear, then accept 1..8.
  - Required: result acc_out=36.
  - Also pulse clear during HOLD. Required: out_valid drops next cycle, and the held result is never handed off.
- **Async reset mid-HOLD:** reach HOLD with acc_out=36, then assert rst_n low between clock edges.
  - Required: out_valid=0 and acc_out=0 before the next clk edge.
